// File: rtl/frame_cmd_loader.sv
// frame_cmd_loader: on each rising edge of the frame request, snapshot the
// exposure/gain settings and push a 5-word sensor register-write sequence
// (exposure x3, gain, frame trigger) into the SPI command FIFO.
module frame_cmd_loader #(
  parameter logic [6:0] ADDR_EXP0 = 7'h2A,
  parameter logic [6:0] ADDR_EXP1 = 7'h2B,
  parameter logic [6:0] ADDR_EXP2 = 7'h2C,
  parameter logic [6:0] ADDR_GAIN = 7'h56,
  parameter logic [6:0] ADDR_TRIG = 7'h46,
  parameter logic [7:0] TRIG_VAL  = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nframe_in,
  input  logic [23:0] exp_time,
  input  logic [7:0]  gain,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [15:0] fifo_din,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [15:0] frame_cnt
);

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned EXP_W    = 24;
  localparam int unsigned GAIN_W   = 8;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned LAST_IDX = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic               nframe_d;
  logic [IDX_W-1:0]   idx;
  logic [EXP_W-1:0]   exp_q;
  logic [GAIN_W-1:0]  gain_q;
  logic               req;

  // Rising-edge detect on the request level
  assign req = nframe_in & ~nframe_d;

  // Write only from PUSH and never into a full FIFO
  assign fifo_wr_en = (state == PUSH) & ~fifo_full;

  // Command word decode from the current index and latched snapshot
  always_comb begin
    fifo_din = {1'b1, ADDR_TRIG, TRIG_VAL};
    case (idx)
      3'd0:    fifo_din = {1'b1, ADDR_EXP0, exp_q[7:0]};
      3'd1:    fifo_din = {1'b1, ADDR_EXP1, exp_q[15:8]};
      3'd2:    fifo_din = {1'b1, ADDR_EXP2, exp_q[23:16]};
      3'd3:    fifo_din = {1'b1, ADDR_GAIN, gain_q};
      default: fifo_din = {1'b1, ADDR_TRIG, TRIG_VAL};
    endcase
  end

  // Sequencer: accept request, push five words, report completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      nframe_d  <= 1'b0;
      idx       <= '0;
      exp_q     <= '0;
      gain_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      nframe_d <= nframe_in;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            exp_q  <= exp_time;
            gain_q <= gain;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= PUSH;
          end
        end
        PUSH: begin
          if (req) begin
            overrun <= 1'b1;
          end
          if (fifo_wr_en) begin
            if (idx == IDX_W'(LAST_IDX)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        DONE: begin
          if (req) begin
            overrun <= 1'b1;
          end
          frame_cnt <= frame_cnt + CNT_W'(1);
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
